// File: rtl/ex_mdu_pkg.sv
// Shared encodings and types for the execute-stage multiply/divide unit.
// Opcode and result-class values follow the existing OpenMIPS-style decode.
package ex_mdu_pkg;

    // aluop_i encodings
    localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

    // alusel_i result classes
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    // Iterative engine operation select
    typedef enum logic {
        MDU_MUL = 1'b0,
        MDU_DIV = 1'b1
    } mdu_op_e;

    // Iterative engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    // True for the ops that occupy the iterative engine
    function automatic logic is_mdu_op(input logic [7:0] op);
        return (op == EXE_MULTU_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_mdu_iter.sv
// Iterative unsigned multiply / restoring divide engine, one bit per cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting; on start latch operands, go BUSY (or DONE for x/0)
// BUSY  | one shift-add or restore-subtract step per cycle, WIDTH steps
// DONE  | result valid on hi/lo for one cycle, then back to IDLE
//
// hi_r/lo_r double as the working registers: for multiply they hold the
// partial product {upper, lower}; for divide hi_r is the partial remainder
// and lo_r shifts the dividend out while the quotient shifts in.
module mdu_iter
    import ex_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       state;
    logic [CW-1:0]    cnt;
    logic             op_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // Datapath for one iteration step, driven only from latched state
    always_comb begin
        mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_r, lo_r[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
    end

    // Sequencer: operand latch, per-step update and state transitions
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= 1'b0;
            b_q   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        b_q  <= b;
                        cnt  <= '0;
                        if ((op == MDU_DIV) && (b == '0)) begin
                            // divide by zero: saturated quotient, dividend as remainder
                            hi_r  <= a;
                            lo_r  <= '1;
                            state <= ST_DONE;
                        end else begin
                            hi_r  <= '0;
                            lo_r  <= a;
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (op_q == MDU_DIV) begin
                        if (!div_diff[WIDTH]) begin
                            hi_r <= div_diff[WIDTH-1:0];
                            lo_r <= {lo_r[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_r <= div_shift[WIDTH-1:0];
                            lo_r <= {lo_r[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi_r <= mul_sum[WIDTH:1];
                        lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
                    end
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: rtl/ex_mdu.sv
// Execute stage: single-cycle ALU, architectural HI/LO and the stall
// interface to the iterative multiply/divide engine.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [7:0]       aluop_i,
    input  logic [2:0]       alusel_i,
    input  logic [WIDTH-1:0] rdata1,
    input  logic [WIDTH-1:0] rdata2,
    input  logic [AW-1:0]    rw_i,
    input  logic             wreg_i,
    output logic [AW-1:0]    rw_o,
    output logic             wreg_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             stall_req_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             mdu_start;
    logic             mdu_op;
    logic             mdu_busy;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_hi;
    logic [WIDTH-1:0] mdu_lo;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] shift_res;
    logic [WIDTH-1:0] arith_res;
    logic [WIDTH-1:0] move_res;
    logic [WIDTH-1:0] alu_res;
    logic             no_wb;

    assign mdu_start = is_mdu_op(aluop_i);
    assign mdu_op    = (aluop_i == EXE_DIVU_OP);
    assign shamt     = rdata1[SHW-1:0];

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (mdu_start),
        .op    (mdu_op),
        .a     (rdata1),
        .b     (rdata2),
        .flush (flush_i),
        .busy  (mdu_busy),
        .done  (mdu_done),
        .hi    (mdu_hi),
        .lo    (mdu_lo)
    );

    // Hold upstream while a mul/div is being accepted or iterating; the
    // DONE cycle releases the pipeline so the next instruction can follow.
    assign stall_req_o = !rst && !flush_i &&
                         ((mdu_start && !mdu_busy && !mdu_done) || mdu_busy);

    // Per-class single-cycle results; unknown ops inside a class give zero
    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;
        case (aluop_i)
            EXE_OR_OP:   logic_res = rdata1 | rdata2;
            EXE_AND_OP:  logic_res = rdata1 & rdata2;
            EXE_XOR_OP:  logic_res = rdata1 ^ rdata2;
            EXE_NOR_OP:  logic_res = ~(rdata1 | rdata2);
            default:     logic_res = '0;
        endcase
        case (aluop_i)
            EXE_SLL_OP:  shift_res = rdata2 << shamt;
            EXE_SRL_OP:  shift_res = rdata2 >> shamt;
            EXE_SRA_OP:  shift_res = $signed(rdata2) >>> shamt;
            default:     shift_res = '0;
        endcase
        case (aluop_i)
            EXE_ADDU_OP: arith_res = rdata1 + rdata2;
            EXE_SUBU_OP: arith_res = rdata1 - rdata2;
            EXE_SLT_OP:  arith_res = {{(WIDTH-1){1'b0}}, ($signed(rdata1) < $signed(rdata2))};
            EXE_SLTU_OP: arith_res = {{(WIDTH-1){1'b0}}, (rdata1 < rdata2)};
            default:     arith_res = '0;
        endcase
        case (aluop_i)
            EXE_MFHI_OP: move_res = hi_q;
            EXE_MFLO_OP: move_res = lo_q;
            default:     move_res = '0;
        endcase
    end

    // Result class mux
    always_comb begin
        alu_res = '0;
        case (alusel_i)
            EXE_RES_LOGIC: alu_res = logic_res;
            EXE_RES_SHIFT: alu_res = shift_res;
            EXE_RES_ARITH: alu_res = arith_res;
            EXE_RES_MOVE:  alu_res = move_res;
            default:       alu_res = '0;
        endcase
    end

    // Ops whose only architectural effect is on HI/LO never write the GPR file
    assign no_wb = (aluop_i == EXE_MULTU_OP) || (aluop_i == EXE_DIVU_OP) ||
                   (aluop_i == EXE_MTHI_OP)  || (aluop_i == EXE_MTLO_OP);

    assign wdata_o = rst ? '0 : alu_res;
    assign rw_o    = rst ? '0 : rw_i;
    assign wreg_o  = !rst && wreg_i && !no_wb;

    // HI/LO update: engine result on its DONE cycle, otherwise MTHI/MTLO
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (!flush_i) begin
            if (mdu_done) begin
                hi_q <= mdu_hi;
                lo_q <= mdu_lo;
            end else if (!stall_req_o && (aluop_i == EXE_MTHI_OP)) begin
                hi_q <= rdata1;
            end else if (!stall_req_o && (aluop_i == EXE_MTLO_OP)) begin
                lo_q <= rdata1;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: scoreboard of expected values pushed when
// an instruction is driven and popped when its result is observed.
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic [7:0]       aluop_i;
    logic [2:0]       alusel_i;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic [AW-1:0]    rw_i;
    logic             wreg_i;
    logic [AW-1:0]    rw_o;
    logic             wreg_o;
    logic [WIDTH-1:0] wdata_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             stall_req_o;

    always #5 clk = ~clk;

    ex_mdu #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .aluop_i     (aluop_i),
        .alusel_i    (alusel_i),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .rw_i        (rw_i),
        .wreg_i      (wreg_i),
        .rw_o        (rw_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .stall_req_o (stall_req_o)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    // Reference model of the single-cycle ops, using the bench's own HI/LO copy
    function automatic logic [31:0] model(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] r;
        sh = a[4:0];
        r  = '0;
        if (sel == EXE_RES_LOGIC) begin
            if (op == EXE_OR_OP)       r = a | b;
            else if (op == EXE_AND_OP) r = a & b;
            else if (op == EXE_XOR_OP) r = a ^ b;
            else if (op == EXE_NOR_OP) r = ~(a | b);
        end else if (sel == EXE_RES_SHIFT) begin
            if (op == EXE_SLL_OP)      r = b << sh;
            else if (op == EXE_SRL_OP) r = b >> sh;
            else if (op == EXE_SRA_OP) r = b[31] ? ~((~b) >> sh) : (b >> sh);
        end else if (sel == EXE_RES_ARITH) begin
            if (op == EXE_ADDU_OP)      r = a + b;
            else if (op == EXE_SUBU_OP) r = a + (~b) + 32'd1;
            else if (op == EXE_SLT_OP)  r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
            else if (op == EXE_SLTU_OP) r = {31'b0, (a < b)};
        end else if (sel == EXE_RES_MOVE) begin
            if (op == EXE_MFHI_OP)      r = hi_m;
            else if (op == EXE_MFLO_OP) r = lo_m;
        end
        return r;
    endfunction

    task automatic set_nop();
        aluop_i  = EXE_NOP_OP;
        alusel_i = EXE_RES_NOP;
        rdata1   = '0;
        rdata2   = '0;
        rw_i     = '0;
        wreg_i   = 1'b0;
    endtask

    // One single-cycle instruction; entered and left #1 after a rising edge
    task automatic issue_alu(input string tag, input logic [7:0] op, input logic [2:0] sel,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rw, input logic wreg);
        logic nowb;
        aluop_i  = op;
        alusel_i = sel;
        rdata1   = a;
        rdata2   = b;
        rw_i     = rw;
        wreg_i   = wreg;
        nowb = (op == EXE_MTHI_OP) || (op == EXE_MTLO_OP) ||
               (op == EXE_MULTU_OP) || (op == EXE_DIVU_OP);
        push({tag, ".wdata"}, model(op, sel, a, b));
        push({tag, ".wreg"},  {31'b0, wreg && !nowb});
        push({tag, ".rw"},    {27'b0, rw});
        push({tag, ".stall"}, 32'd0);
        @(negedge clk);
        pop_chk(wdata_o);
        pop_chk({31'b0, wreg_o});
        pop_chk({27'b0, rw_o});
        pop_chk({31'b0, stall_req_o});
        @(posedge clk); #1;
        if (op == EXE_MTHI_OP) hi_m = a;
        if (op == EXE_MTLO_OP) lo_m = a;
    endtask

    // One MULTU/DIVU: count stall cycles, then check HI/LO just after the write edge
    task automatic issue_mdu(input string tag, input logic [7:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        int          stall_cnt;
        logic [63:0] prod;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_stall;
        if (op == EXE_MULTU_OP) begin
            prod      = {32'b0, a} * {32'b0, b};
            exp_hi    = prod[63:32];
            exp_lo    = prod[31:0];
            exp_stall = WIDTH + 1;
        end else if (b == 32'd0) begin
            exp_hi    = a;
            exp_lo    = 32'hFFFF_FFFF;
            exp_stall = 1;
        end else begin
            exp_hi    = a % b;
            exp_lo    = a / b;
            exp_stall = WIDTH + 1;
        end
        aluop_i  = op;
        alusel_i = EXE_RES_NOP;
        rdata1   = a;
        rdata2   = b;
        rw_i     = 5'd9;
        wreg_i   = 1'b1;
        push({tag, ".stall_cycles"}, 32'(exp_stall));
        push({tag, ".wreg"},         32'd0);
        push({tag, ".hi"},           exp_hi);
        push({tag, ".lo"},           exp_lo);
        stall_cnt = 0;
        @(negedge clk);
        while (stall_req_o && stall_cnt < 200) begin
            stall_cnt++;
            @(negedge clk);
        end
        pop_chk(32'(stall_cnt));
        pop_chk({31'b0, wreg_o});
        @(posedge clk); #1;
        pop_chk(hi_o);
        pop_chk(lo_o);
        hi_m = exp_hi;
        lo_m = exp_lo;
    endtask

    logic [7:0] tbl_op[12] = '{EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_OR_OP,
                               EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP, EXE_ADDU_OP,
                               EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_MFLO_OP};
    logic [2:0] tbl_sel[12] = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC,
                                EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_ARITH,
                                EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_MOVE};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        flush_i  = 1'b0;
        aluop_i  = EXE_OR_OP;
        alusel_i = EXE_RES_LOGIC;
        rdata1   = 32'h1234_0000;
        rdata2   = 32'h0000_5678;
        rw_i     = 5'd5;
        wreg_i   = 1'b1;

        // Reset holds outputs quiet even with a live OR on the inputs
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.wdata", wdata_o, 32'd0);
        chk("rst.wreg",  {31'b0, wreg_o}, 32'd0);
        chk("rst.rw",    {27'b0, rw_o}, 32'd0);
        aluop_i = EXE_MULTU_OP;
        @(negedge clk);
        chk("rst.stall", {31'b0, stall_req_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_nop();
        chk("rst.hi", hi_o, 32'd0);
        chk("rst.lo", lo_o, 32'd0);

        issue_alu("or_basic", EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h00FF_0000, 5'd3, 1'b1);
        issue_alu("mthi", EXE_MTHI_OP, EXE_RES_NOP, 32'h1234_5678, 32'h0, 5'd4, 1'b1);
        issue_alu("mfhi_after_mthi", EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd6, 1'b1);
        issue_alu("sra_sign", EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd7, 1'b1);
        issue_alu("sll_max", EXE_SLL_OP, EXE_RES_SHIFT, 32'd31, 32'h0000_0003, 5'd8, 1'b1);
        issue_alu("srl_zero", EXE_SRL_OP, EXE_RES_SHIFT, 32'hFFFF_FFE0, 32'hA5A5_A5A5, 5'd8, 1'b1);
        issue_alu("addu_wrap", EXE_ADDU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd2, 5'd10, 1'b1);
        issue_alu("subu_wrap", EXE_SUBU_OP, EXE_RES_ARITH, 32'd1, 32'd2, 5'd10, 1'b1);
        issue_alu("slt_neg", EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd11, 1'b1);
        issue_alu("sltu_neg", EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd11, 1'b1);
        issue_alu("mtlo", EXE_MTLO_OP, EXE_RES_NOP, 32'hCAFE_0001, 32'h0, 5'd12, 1'b1);
        issue_alu("mflo_after_mtlo", EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd13, 1'b0);
        issue_alu("unknown_op", 8'hFF, EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 1'b1);
        issue_alu("unknown_sel", EXE_OR_OP, 3'b111, 32'hFFFF_FFFF, 32'h1, 5'd14, 1'b1);

        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 3; j++) begin
                issue_alu($sformatf("tbl%0d_%0d", i, j), tbl_op[i], tbl_sel[i],
                          $urandom(), $urandom(), 5'($urandom_range(0, 31)), 1'b1);
            end
        end

        issue_mdu("multu_max", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2);
        issue_alu("mfhi_after_multu", EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd2, 1'b1);
        issue_mdu("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7);
        issue_alu("mflo_after_divu", EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd2, 1'b1);
        issue_mdu("divu_by_zero", EXE_DIVU_OP, 32'd5, 32'd0);
        issue_mdu("multu_rand", EXE_MULTU_OP, $urandom(), $urandom());
        issue_mdu("divu_rand", EXE_DIVU_OP, $urandom(), 32'($urandom_range(1, 65535)));

        // Flush at BUSY step 10: engine abandons the op and HI/LO keep their values
        aluop_i  = EXE_MULTU_OP;
        alusel_i = EXE_RES_NOP;
        rdata1   = 32'hDEAD_BEEF;
        rdata2   = 32'h0000_1234;
        @(posedge clk); #1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush.stall_same_cycle", {31'b0, stall_req_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        set_nop();
        @(negedge clk);
        chk("flush.stall_next", {31'b0, stall_req_o}, 32'd0);
        chk("flush.hi_next", hi_o, hi_m);
        chk("flush.lo_next", lo_o, lo_m);
        repeat (40) @(posedge clk);
        #1;
        chk("flush.hi_later", hi_o, hi_m);
        chk("flush.lo_later", lo_o, lo_m);

        // Reset mid-divide clears HI/LO and drops the stall
        aluop_i  = EXE_DIVU_OP;
        alusel_i = EXE_RES_NOP;
        rdata1   = 32'hFFFF_0000;
        rdata2   = 32'd3;
        rw_i     = 5'd17;
        wreg_i   = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.stall", {31'b0, stall_req_o}, 32'd0);
        chk("rst_mid.wreg",  {31'b0, wreg_o}, 32'd0);
        chk("rst_mid.rw",    {27'b0, rw_o}, 32'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        hi_m = '0;
        lo_m = '0;
        chk("rst_mid.hi", hi_o, 32'd0);
        chk("rst_mid.lo", lo_o, 32'd0);
        issue_alu("or_after_rst", EXE_OR_OP, EXE_RES_LOGIC, 32'h0F0F_0000, 32'h0000_00F0, 5'd21, 1'b1);
        set_nop();
        repeat (40) @(posedge clk);
        #1;
        chk("rst_mid.hi_later", hi_o, 32'd0);
        chk("rst_mid.lo_later", lo_o, 32'd0);

        // Back-to-back MTHI/MFHI after everything else
        issue_alu("mthi_final", EXE_MTHI_OP, EXE_RES_NOP, 32'h0BAD_F00D, 32'h0, 5'd1, 1'b1);
        issue_alu("mfhi_final", EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width in bits (power of two, at least 8).
REQ-002 SHALL have parameter AW, default 5: register address width.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port flush_i, input, 1: abort the in-flight instruction.
REQ-006 SHALL have ports aluop_i (input, 8) and alusel_i (input, 3): operation code and result class.
REQ-007 SHALL have ports rdata1 and rdata2, input, WIDTH each: operands.
REQ-008 SHALL have ports rw_i (input, AW) and wreg_i (input, 1): destination register and write enable.
REQ-009 SHALL have ports rw_o (output, AW), wreg_o (output, 1) and wdata_o (output, WIDTH): writeback bundle.
REQ-010 SHALL have ports hi_o and lo_o, output, WIDTH each: architectural HI and LO registers.
REQ-011 SHALL have port stall_req_o, output, 1: request to hold the upstream pipeline.

Function
REQ-012 SHALL compute single-cycle ops combinationally in the cycle presented:
- OR, AND, XOR, NOR
- SLL, SRL, SRA: shift amount is rdata1[log2(WIDTH)-1:0]; value shifted is rdata2
- ADDU, SUBU: modulo 2^WIDTH
- SLT (signed), SLTU: result 1 or 0, zero-extended
- MFHI, MFLO
REQ-013 SHALL select wdata_o by alusel_i class (LOGIC, SHIFT, ARITH, MOVE); an unknown class or op SHALL give wdata_o = 0.
REQ-014 SHALL drive rw_o = rw_i, and wreg_o = wreg_i except wreg_o = 0 for MULTU, DIVU, MTHI, MTLO.
REQ-015 MTHI/MTLO SHALL write rdata1 into HI/LO at the clock edge ending the cycle, provided stall_req_o = 0 and flush_i = 0.
REQ-016 MULTU and DIVU SHALL use a single iterative engine with FSM states IDLE, BUSY and DONE.
REQ-017 IDLE with MULTU/DIVU present:
- stall_req_o = 1 combinationally
- operands latched at the edge
- next state BUSY, iteration counter = 0
REQ-018 BUSY SHALL perform one shift-add (MULTU) or one restoring-subtract (DIVU) step per cycle, hold stall_req_o = 1, and go to DONE after WIDTH steps.
REQ-019 DONE SHALL:
- hold stall_req_o = 0
- at the closing edge write HI/LO (MULTU: HI = upper product, LO = lower product; DIVU: LO = quotient, HI = remainder)
- return to IDLE
REQ-020 Total MULTU/DIVU occupancy SHALL be WIDTH+2 cycles, with stall_req_o high for WIDTH+1 of them.
REQ-021 DIVU with rdata2 = 0 SHALL go IDLE to DONE directly (stall high 1 cycle) and give LO = all-ones, HI = rdata1.
REQ-022 flush_i = 1 in any state SHALL return the FSM to IDLE next cycle, suppress the HI/LO write, and deassert stall_req_o that cycle.
REQ-023 Upstream SHALL hold aluop_i and the operands stable while stall_req_o = 1; the engine SHALL use only its latched copies in BUSY.
REQ-024 MFHI/MFLO SHALL read the registered HI/LO; a write at edge N SHALL be visible to an MFHI in cycle N+1.

Reset
REQ-025 rst SHALL force, at the next edge: FSM = IDLE, counter = 0, HI = LO = 0, latched operands = 0.
REQ-026 While rst = 1, stall_req_o = 0, wreg_o = 0, wdata_o = 0, and rw_o = 0 SHALL hold.
REQ-027 rst SHALL take precedence over flush_i and over any in-flight operation, with no HI/LO write.

Structure
REQ-028 Opcode and alusel encodings (including new SLTU, MULTU, DIVU, MTHI, MTLO, MFHI, MFLO) SHALL live in the shared defines include, alongside EXE_OR_OP and EXE_RES_LOGIC.
REQ-029 The iterative engine SHALL be one sub-module, mdu_iter, with ports start, op, a, b, flush, busy, done, hi, lo; the combinational ALU and HI/LO registers SHALL stay in ex_mdu.

Verification
REQ-030 OR 0x0000F0F0 with 0x00FF0000, wreg_i = 1, rw_i = 3 -> wdata_o = 0x00FFF0F0, wreg_o = 1, rw_o = 3, stall low.
REQ-031 MULTU 0xFFFFFFFF x 2 -> stall high 33 cycles; then HI = 0x00000001, LO = 0xFFFFFFFE; next-cycle MFHI gives 1.
REQ-032 DIVU 100 / 7 -> after 34 cycles LO = 14, HI = 2; DIVU 5 / 0 -> stall high 1 cycle, LO = 0xFFFFFFFF, HI = 5.
REQ-033 MULTU started, flush_i pulsed at BUSY step 10 -> IDLE next cycle, stall low, HI/LO unchanged.
REQ-034 rst asserted mid-DIVU -> next cycle HI = LO = 0, stall low; a following OR executes normally.
REQ-035 MTHI 0x12345678, then MFHI next cycle -> wdata_o = 0x12345678; SRA with rdata2 = 0x80000000, shift 4 -> 0xF8000000.
